// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and default width for the shift-add multiplier
package mult_pkg;
  localparam int MULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/twos_negate.sv
// twos_negate: combinational conditional two's-complement negation
module twos_negate #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic         neg,
  output logic [N-1:0] y
);
  assign y = neg ? -x : x;
endmodule

// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: sequential shift-add multiplier with signed/unsigned mode and start/busy/done handshake
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               sign,
  output logic               zflag
);
  localparam int CW = $clog2(WIDTH);
  state_t state, nxt;
  logic [WIDTH-1:0] acc, mplr, mcand, abs_a, abs_b;
  logic [CW-1:0] cnt;
  logic neg, smode;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] fixed;
  twos_negate #(.N(WIDTH)) u_abs_a (
    .x(multiplicand), .neg(signed_mode & multiplicand[WIDTH-1]), .y(abs_a)
  );
  twos_negate #(.N(WIDTH)) u_abs_b (
    .x(multiplier), .neg(signed_mode & multiplier[WIDTH-1]), .y(abs_b)
  );
  twos_negate #(.N(2*WIDTH)) u_fix (
    .x({acc, mplr}), .neg(neg), .y(fixed)
  );
  always_comb begin
    nxt = state == IDLE ? (start ? RUN : IDLE)
        : state == RUN  ? (cnt == CW'(WIDTH-1) ? FIX : RUN)
        : IDLE;
    busy = state != IDLE;
    sum = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mplr   <= '0;
      mcand  <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      smode  <= 1'b0;
      result <= '0;
      sign   <= 1'b0;
      zflag  <= 1'b1;
      done   <= 1'b0;
    end else begin
      state <= nxt;
      done  <= state == FIX;
      if (state == IDLE && start) begin
        mcand <= abs_a;
        mplr  <= abs_b;
        acc   <= '0;
        cnt   <= '0;
        neg   <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
        smode <= signed_mode;
      end
      // the carry lands in the accumulator MSB as the whole register shifts right
      if (state == RUN) begin
        acc  <= sum[WIDTH:1];
        mplr <= {sum[0], mplr[WIDTH-1:1]};
        cnt  <= cnt + CW'(1);
      end
      if (state == FIX) begin
        result <= fixed;
        sign   <= smode & fixed[2*WIDTH-1];
        zflag  <= fixed == '0;
      end
    end
  end
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb_seq_shift_add_mult: table-driven and scoreboard checks of the shift-add multiplier
module tb_seq_shift_add_mult;
  logic clk = 1'b0;
  logic reset, start, signed_mode;
  logic [7:0] multiplier, multiplicand;
  logic busy, done, sign, zflag;
  logic [15:0] result;
  logic start16, signed_mode16;
  logic [15:0] multiplier16, multiplicand16;
  logic busy16, done16, sign16, zflag16;
  logic [31:0] result16;
  int checks = 0;
  int errors = 0;
  logic [15:0] sbq[$];
  typedef struct {
    logic       sm;
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] p;
  } vec_t;
  vec_t tbl[6];

  seq_shift_add_mult #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .multiplier(multiplier), .multiplicand(multiplicand),
    .busy(busy), .done(done), .result(result), .sign(sign), .zflag(zflag)
  );
  seq_shift_add_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .signed_mode(signed_mode16),
    .multiplier(multiplier16), .multiplicand(multiplicand16),
    .busy(busy16), .done(done16), .result(result16), .sign(sign16), .zflag(zflag16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic sm, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] sa, sb;
    sa = sm ? {{8{a[7]}}, a} : {8'h00, a};
    sb = sm ? {{8{b[7]}}, b} : {8'h00, b};
    return sa * sb;
  endfunction

  task automatic launch(input logic sm, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    @(posedge clk);
    #1;
    start = 1'b1;
    signed_mode = sm;
    multiplicand = a;
    multiplier = b;
    sbq.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int from, input string nm);
    int lat;
    logic seen;
    logic [15:0] exp;
    lat = from;
    seen = 1'b0;
    while (lat < 40 && !seen) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = done;
    end
    chk({nm, "_done_seen"}, {31'b0, seen}, 32'd1);
    chk({nm, "_latency"}, lat, 32'd9);
    if (sbq.size() == 0) begin
      chk({nm, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sbq.pop_front();
      chk({nm, "_result"}, {16'b0, result}, {16'b0, exp});
      chk({nm, "_sign"}, {31'b0, sign}, {31'b0, signed_mode & exp[15]});
      chk({nm, "_zflag"}, {31'b0, zflag}, {31'b0, exp == 16'h0});
    end
  endtask

  initial begin
    int lat;
    int dcount;
    logic [7:0] ra, rb;
    logic rs;
    tbl[0] = '{1'b0, 8'd3,  8'd10, 16'h001E};
    tbl[1] = '{1'b1, 8'hFB, 8'h07, 16'hFFDD};
    tbl[2] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    tbl[3] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    tbl[4] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    tbl[5] = '{1'b1, 8'h80, 8'h01, 16'hFF80};
    reset = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    multiplier = '0;
    multiplicand = '0;
    start16 = 1'b0;
    signed_mode16 = 1'b0;
    multiplier16 = '0;
    multiplicand16 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", {16'b0, result}, 32'd0);
    chk("rst_sign", {31'b0, sign}, 32'd0);
    chk("rst_zflag", {31'b0, zflag}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      launch(tbl[i].sm, tbl[i].a, tbl[i].b, tbl[i].p);
      wait_done(0, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      launch(rs, ra, rb, model(rs, ra, rb));
      wait_done(0, $sformatf("rnd%0d", i));
    end

    // signed zero with neg=1, then start held in the done cycle
    launch(1'b1, 8'h00, 8'hF7, 16'h0000);
    wait_done(0, "zero_neg");
    start = 1'b1;
    signed_mode = 1'b0;
    multiplicand = 8'd2;
    multiplier = 8'd2;
    sbq.push_back(16'd4);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(0, "back2back");

    // start during RUN is ignored
    launch(1'b0, 8'd3, 8'd10, 16'd30);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
    multiplicand = 8'd7;
    multiplier = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ignore_busy", {31'b0, busy}, 32'd1);
    wait_done(3, "ignore");

    // reset mid-operation aborts with no done
    @(posedge clk);
    #1;
    start = 1'b1;
    signed_mode = 1'b0;
    multiplicand = 8'd5;
    multiplier = 8'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_zflag", {31'b0, zflag}, 32'd1);
    chk("abort_result", {16'b0, result}, 32'd0);
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", dcount, 32'd0);

    // reset wins over start on the same edge
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    chk("rst_prio_busy", {31'b0, busy}, 32'd0);

    // WIDTH=16 signed extreme
    @(posedge clk);
    #1;
    start16 = 1'b1;
    signed_mode16 = 1'b1;
    multiplicand16 = 16'h8000;
    multiplier16 = 16'h7FFF;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    lat = 0;
    dcount = 0;
    while (lat < 60 && dcount == 0) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done16) dcount = 1;
    end
    chk("w16_done_seen", dcount, 32'd1);
    chk("w16_latency", lat, 32'd17);
    chk("w16_result", result16, 32'hC0008000);
    chk("w16_sign", {31'b0, sign16}, 32'd1);
    chk("w16_zflag", {31'b0, zflag16}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
